// File: rtl/vga_draw_pkg.sv
// Shared types, widths and address packing for the VGA line-drawing blocks.
package vga_draw_pkg;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned ERR_W   = 13;
  localparam int unsigned E2_W    = 14;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PLOT,
    DONE
  } state_t;

  // Frame buffer is addressed as {row, column} with a 1024-byte row stride.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [X_W-1:0]    x,
                                                  input logic [Y_W-1:0]    y);
    return base + ADDR_W'({y, x});
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// Combinational Bresenham step: next err/x/y from the current point and error term.
module bresenham_step
  import vga_draw_pkg::*;
(
  input  logic signed [ERR_W-1:0] i_err,
  input  logic signed [ERR_W-1:0] i_dx,
  input  logic signed [ERR_W-1:0] i_dy,
  input  logic [X_W-1:0]          i_x,
  input  logic [Y_W-1:0]          i_y,
  input  logic                    i_sx_neg,
  input  logic                    i_sy_neg,
  output logic signed [ERR_W-1:0] o_err,
  output logic [X_W-1:0]          o_x,
  output logic [Y_W-1:0]          o_y
);

  logic signed [E2_W-1:0] w_e2;
  logic signed [E2_W-1:0] w_dx_ext;
  logic signed [E2_W-1:0] w_dy_ext;
  logic                   w_step_x;
  logic                   w_step_y;

  // Both decisions compare against the pre-step error.
  always_comb begin
    w_e2     = {i_err, 1'b0};
    w_dx_ext = {i_dx[ERR_W-1], i_dx};
    w_dy_ext = {i_dy[ERR_W-1], i_dy};
    w_step_x = (w_e2 >= w_dy_ext);
    w_step_y = (w_e2 <= w_dx_ext);
    o_err    = i_err;
    o_x      = i_x;
    o_y      = i_y;
    if (w_step_x) begin
      o_err = o_err + i_dy;
      o_x   = i_sx_neg ? (i_x - X_W'(1)) : (i_x + X_W'(1));
    end
    if (w_step_y) begin
      o_err = o_err + i_dx;
      o_y   = i_sy_neg ? (i_y - Y_W'(1)) : (i_y + Y_W'(1));
    end
  end

endmodule

// File: rtl/line_pixel_writer.sv
// Bresenham line rasteriser writing RGB332 pixels over Avalon-MM, one point per clock,
// clipping points outside the visible area.
module line_pixel_writer
  import vga_draw_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0800_0000,
  parameter int unsigned       H_RES     = 640,
  parameter int unsigned       V_RES     = 480
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x0,
  input  logic [X_W-1:0]      cmd_x1,
  input  logic [Y_W-1:0]      cmd_y0,
  input  logic [Y_W-1:0]      cmd_y1,
  input  logic [COLOR_W-1:0]  cmd_color,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_write,
  output logic [COLOR_W-1:0]  m_writedata,
  input  logic                m_waitrequest,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pixel_count
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [X_W-1:0]          r_x;
  logic [X_W-1:0]          r_x1;
  logic [Y_W-1:0]          r_y;
  logic [Y_W-1:0]          r_y1;
  logic [COLOR_W-1:0]      r_color;
  logic signed [ERR_W-1:0] r_dx;
  logic signed [ERR_W-1:0] r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sx_neg;
  logic                    r_sy_neg;
  logic                    r_cmd_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_m_write;
  logic [ADDR_W-1:0]       r_m_address;
  logic [COLOR_W-1:0]      r_m_writedata;
  logic [CNT_W-1:0]        r_pixel_count;

  logic [X_W-1:0]          w_step_x;
  logic [Y_W-1:0]          w_step_y;
  logic signed [ERR_W-1:0] w_step_err;
  logic [X_W-1:0]          w_dx_abs;
  logic [Y_W-1:0]          w_dy_abs;
  logic signed [ERR_W-1:0] w_setup_dx;
  logic signed [ERR_W-1:0] w_setup_dy;
  logic [X_W-1:0]          w_pt_x;
  logic [Y_W-1:0]          w_pt_y;
  logic                    w_pt_in_range;
  logic                    w_cmd_fire;
  logic                    w_accept;
  logic                    w_retire;
  logic                    w_last;

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign m_write     = r_m_write;
  assign m_address   = r_m_address;
  assign m_writedata = r_m_writedata;
  assign pixel_count = r_pixel_count;

  bresenham_step u_step (
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_x      (r_x),
    .i_y      (r_y),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .o_err    (w_step_err),
    .o_x      (w_step_x),
    .o_y      (w_step_y)
  );

  // The point loaded into the bus registers is the start point in SETUP, else the stepped point.
  always_comb begin
    w_cmd_fire    = (r_state == IDLE) && r_cmd_ready && cmd_valid;
    w_accept      = r_m_write && !m_waitrequest;
    w_retire      = !r_m_write || !m_waitrequest;
    w_last        = (r_x == r_x1) && (r_y == r_y1);
    w_dx_abs      = (r_x1 >= r_x) ? (r_x1 - r_x) : (r_x - r_x1);
    w_dy_abs      = (r_y1 >= r_y) ? (r_y1 - r_y) : (r_y - r_y1);
    w_setup_dx    = ERR_W'(w_dx_abs);
    w_setup_dy    = -ERR_W'(w_dy_abs);
    w_pt_x        = (r_state == SETUP) ? r_x : w_step_x;
    w_pt_y        = (r_state == SETUP) ? r_y : w_step_y;
    w_pt_in_range = (32'(w_pt_x) < H_RES) && (32'(w_pt_y) < V_RES);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = PLOT;
      PLOT:    if (w_retire && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_x1          <= '0;
      r_y1          <= '0;
      r_color       <= '0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_err         <= '0;
      r_sx_neg      <= 1'b0;
      r_sy_neg      <= 1'b0;
      r_cmd_ready   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_m_write     <= 1'b0;
      r_m_address   <= '0;
      r_m_writedata <= '0;
      r_pixel_count <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_x     <= cmd_x0;
            r_y     <= cmd_y0;
            r_x1    <= cmd_x1;
            r_y1    <= cmd_y1;
            r_color <= cmd_color;
          end
        end
        SETUP: begin
          r_dx          <= w_setup_dx;
          r_dy          <= w_setup_dy;
          r_err         <= w_setup_dx + w_setup_dy;
          r_sx_neg      <= (r_x1 < r_x);
          r_sy_neg      <= (r_y1 < r_y);
          r_pixel_count <= '0;
          r_m_write     <= w_pt_in_range;
          r_m_address   <= pack_addr(BASE_ADDR, w_pt_x, w_pt_y);
          r_m_writedata <= r_color;
        end
        PLOT: begin
          if (w_accept) r_pixel_count <= r_pixel_count + CNT_W'(1);
          // A clipped point (no write) retires immediately; a stalled write holds everything.
          if (w_retire) begin
            if (w_last) begin
              r_m_write <= 1'b0;
            end else begin
              r_x         <= w_step_x;
              r_y         <= w_step_y;
              r_err       <= w_step_err;
              r_m_write   <= w_pt_in_range;
              r_m_address <= pack_addr(BASE_ADDR, w_pt_x, w_pt_y);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_pixel_writer.sv
// Directed bench for line_pixel_writer: an integer line model predicts every write,
// a per-cycle monitor acts as the Avalon slave and checks the bus against it.
module tb_line_pixel_writer;

  localparam logic [31:0] BASE = 32'h0800_0000;
  localparam int          H    = 640;
  localparam int          V    = 480;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0;
  logic [9:0]  cmd_x1 = '0;
  logic [8:0]  cmd_y0 = '0;
  logic [8:0]  cmd_y1 = '0;
  logic [7:0]  cmd_color = '0;
  logic [31:0] m_address;
  logic        m_write;
  logic [7:0]  m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic [10:0] pixel_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_color = '0;
  int          exp_total = 0;
  int          model_acc = 0;
  int          done_cnt = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          first_wr_cyc = -1;
  int          acc_cyc[$];
  logic [31:0] acc_addr[$];
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  int          n_before = 0;

  always #5 clk = ~clk;

  line_pixel_writer #(.BASE_ADDR(BASE), .H_RES(H), .V_RES(V)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x0        (cmd_x0),
    .cmd_x1        (cmd_x1),
    .cmd_y0        (cmd_y0),
    .cmd_y1        (cmd_y1),
    .cmd_color     (cmd_color),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .done          (done),
    .pixel_count   (pixel_count)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    if (i < acc_addr.size()) return acc_addr[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int qc(input int i);
    if (i < acc_cyc.size()) return acc_cyc[i];
    return -1000;
  endfunction

  // Reference line: the integer Bresenham walk, keeping only on-screen points.
  task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [7:0] c);
    int x, y, dx, dy, sx, sy, err, e2;
    x   = x0;
    y   = y0;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    exp_q.delete();
    acc_cyc.delete();
    acc_addr.delete();
    for (int k = 0; k < 4096; k++) begin
      if (x < H && y < V) exp_q.push_back(BASE + 32'(y * 1024 + x));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    exp_total    = exp_q.size();
    exp_color    = c;
    model_acc    = 0;
    done_cnt     = 0;
    stall_seen   = 0;
    first_wr_cyc = -1;
  endtask

  // One clock: sample at the falling edge, play the slave, check the bus.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      prev_stalled  = 1'b0;
      m_waitrequest = 1'b0;
    end else begin
      if (prev_stalled) begin
        chk("hold_write", longint'(m_write), 1);
        chk("hold_addr", longint'(m_address), longint'(prev_addr));
        chk("hold_data", longint'(m_writedata), longint'(prev_data));
      end
      if (m_write && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (m_write && stall_left > 0) begin
        m_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
      end else begin
        m_waitrequest = 1'b0;
      end
      if (m_write && !m_waitrequest) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h expected no write", m_address);
        end else begin
          chk("wr_addr", longint'(m_address), longint'(exp_q.pop_front()));
          chk("wr_data", longint'(m_writedata), longint'(exp_color));
        end
        acc_cyc.push_back(cyc);
        acc_addr.push_back(m_address);
        model_acc++;
      end
      if (done) begin
        done_cnt++;
        chk("count_at_done", longint'(pixel_count), longint'(exp_total));
        chk("pending_at_done", longint'(exp_q.size()), 0);
      end
      prev_stalled = m_write && m_waitrequest;
      prev_addr    = m_address;
      prev_data    = m_writedata;
    end
  endtask

  // Handshake a command, then hold cmd_valid with junk fields while busy.
  task automatic issue(input int x0, input int y0, input int x1, input int y1,
                       input logic [7:0] c);
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin tick(); k++; end
    chk("ready_before_cmd", longint'(cmd_ready), 1);
    cmd_x0    = 10'(x0);
    cmd_y0    = 9'(y0);
    cmd_x1    = 10'(x1);
    cmd_y1    = 9'(y1);
    cmd_color = c;
    cmd_valid = 1'b1;
    tick();
    chk("busy_after_accept", longint'(busy), 1);
    chk("ready_low_busy", longint'(cmd_ready), 0);
    cmd_x0    = 10'd1;
    cmd_y0    = 9'd1;
    cmd_x1    = 10'd9;
    cmd_y1    = 9'd9;
    cmd_color = 8'h55;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin tick(); k++; end
    chk("done_seen", longint'(done_cnt), 1);
    tick();
    chk("done_one_cycle", longint'(done_cnt), 1);
    chk("idle_busy", longint'(busy), 0);
    chk("idle_ready", longint'(cmd_ready), 1);
  endtask

  initial begin
    #3;
    chk("rst_cmd_ready", longint'(cmd_ready), 0);
    chk("rst_m_write", longint'(m_write), 0);
    chk("rst_m_address", longint'(m_address), 0);
    chk("rst_m_writedata", longint'(m_writedata), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_pixel_count", longint'(pixel_count), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", longint'(cmd_ready), 1);

    // Horizontal run at zero wait states.
    model_line(0, 0, 3, 0, 8'hE0);
    issue(0, 0, 3, 0, 8'hE0);
    wait_done();
    chk("t1_count", longint'(pixel_count), 4);
    chk("t1_a0", longint'(qa(0)), longint'(BASE));
    chk("t1_a1", longint'(qa(1)), longint'(BASE + 32'd1));
    chk("t1_a2", longint'(qa(2)), longint'(BASE + 32'd2));
    chk("t1_a3", longint'(qa(3)), longint'(BASE + 32'd3));
    chk("t1_back_to_back", longint'(qc(3) - qc(0)), 3);

    // Diagonal.
    model_line(0, 0, 2, 2, 8'h1C);
    issue(0, 0, 2, 2, 8'h1C);
    wait_done();
    chk("t2_count", longint'(pixel_count), 3);
    chk("t2_a0", longint'(qa(0)), longint'(BASE));
    chk("t2_a1", longint'(qa(1)), longint'(BASE + 32'h401));
    chk("t2_a2", longint'(qa(2)), longint'(BASE + 32'h802));

    // Single point.
    model_line(5, 7, 5, 7, 8'h03);
    issue(5, 7, 5, 7, 8'h03);
    wait_done();
    chk("t3_count", longint'(pixel_count), 1);
    chk("t3_a0", longint'(qa(0)), longint'(BASE + 32'h1C05));

    // Three stall cycles on the first write.
    model_line(0, 0, 1, 0, 8'hAA);
    stall_left = 3;
    issue(0, 0, 1, 0, 8'hAA);
    wait_done();
    chk("t4_count", longint'(pixel_count), 2);
    chk("t4_stalls", longint'(stall_seen), 3);
    chk("t4_first_held", longint'(qc(0) - first_wr_cyc), 3);
    chk("t4_second_next", longint'(qc(1) - qc(0)), 1);
    chk("t4_a1", longint'(qa(1)), longint'(BASE + 32'd1));

    // Right-edge clipping.
    model_line(638, 0, 641, 0, 8'hFF);
    issue(638, 0, 641, 0, 8'hFF);
    wait_done();
    chk("t5_count", longint'(pixel_count), 2);
    chk("t5_a0", longint'(qa(0)), longint'(BASE + 32'd638));
    chk("t5_a1", longint'(qa(1)), longint'(BASE + 32'd639));

    // Steep line: one pixel per row.
    model_line(10, 20, 13, 40, 8'h92);
    issue(10, 20, 13, 40, 8'h92);
    wait_done();
    chk("t6_count", longint'(pixel_count), 21);

    // Reset in the middle of a long line.
    model_line(0, 0, 100, 0, 8'h7F);
    issue(0, 0, 100, 0, 8'h7F);
    for (int k = 0; k < 50 && model_acc < 5; k++) tick();
    chk("t7_progress", longint'(model_acc), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_write_dropped", longint'(m_write), 0);
    chk("t7_busy_dropped", longint'(busy), 0);
    chk("t7_ready_in_reset", longint'(cmd_ready), 0);
    chk("t7_count_cleared", longint'(pixel_count), 0);
    chk("t7_addr_cleared", longint'(m_address), 0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t7_ready_after", longint'(cmd_ready), 1);
    n_before = acc_addr.size();
    repeat (20) tick();
    chk("t7_no_writes", longint'(acc_addr.size()), longint'(n_before));
    chk("t7_idle", longint'(busy), 0);

    // Negative direction on both axes after recovery.
    model_line(3, 2, 0, 0, 8'h49);
    issue(3, 2, 0, 0, 8'h49);
    wait_done();
    chk("t8_count", longint'(pixel_count), 4);
    chk("t8_a0", longint'(qa(0)), longint'(BASE + 32'h803));
    chk("t8_a1", longint'(qa(1)), longint'(BASE + 32'h402));
    chk("t8_a3", longint'(qa(3)), longint'(BASE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_pixel_writer.md
LINE_PIXEL_WRITER -- requirements
Module: line_pixel_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0800_0000, pixel buffer byte base address.
REQ-002 SHALL have parameter H_RES, default 640, visible width in pixels.
REQ-003 SHALL have parameter V_RES, default 480, visible height in pixels.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid  input  1  line command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have ports cmd_x0, cmd_x1  input  10 each  endpoint columns, unsigned.
REQ-009 SHALL have ports cmd_y0, cmd_y1  input  9 each  endpoint rows, unsigned.
REQ-010 SHALL have port cmd_color  input  8  RGB332 pixel value.
REQ-011 SHALL have port m_address  output  32  Avalon-MM byte address.
REQ-012 SHALL have port m_write  output  1  Avalon-MM write request.
REQ-013 SHALL have port m_writedata  output  8  pixel data.
REQ-014 SHALL have port m_waitrequest  input  1  slave stall.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at line completion.
REQ-017 SHALL have port pixel_count  output  11  accepted writes for the current or last line.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, PLOT, DONE.
REQ-019 SHALL assert cmd_ready only in IDLE; a handshake latches all cmd_* fields and moves to SETUP.
REQ-020 SHALL, in SETUP (one cycle), compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1 or -1 (+1 when equal), err=dx+dy, clear pixel_count, then enter PLOT.
REQ-021 SHALL hold err as 13-bit signed and e2=2*err as 14-bit signed, with no overflow for any 10/9-bit coordinates.
REQ-022 SHALL, in PLOT with the current (x,y) in range (x<H_RES, y<V_RES), drive m_write=1, m_address=BASE_ADDR+{y,x} (y in bits 18:10, x in bits 9:0), m_writedata=color.
REQ-023 SHALL hold m_address, m_writedata and m_write stable while m_waitrequest=1.
REQ-024 SHALL treat a write as accepted in the cycle m_write=1 and m_waitrequest=0, and increment pixel_count on that cycle.
REQ-025 SHALL, when the current point is out of range, drive m_write=0 and treat the point as immediately retired (clipping).
REQ-026 SHALL, on retiring a point with (x,y)==(x1,y1), go to DONE; otherwise apply the Bresenham step in the same cycle: if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates SHALL use the pre-step err.
REQ-027 SHALL pulse done for exactly one cycle in DONE and return to IDLE on the next cycle.
REQ-028 SHALL retire one point per cycle at zero wait states, for a throughput of 1 pixel/clk.
REQ-029 SHALL treat x0==x1 and y0==y1 (single point) as a one-pixel line.
REQ-030 SHALL ignore cmd_valid while busy; no command is queued.

Reset
REQ-031 SHALL, on reset_n low, asynchronously force state=IDLE, cmd_ready=0 during reset, m_write=0, m_address=0, m_writedata=0, busy=0, done=0, pixel_count=0.
REQ-032 SHALL abandon any in-flight line on reset mid-operation, with no write issued after reset deasserts until a new command arrives.
REQ-033 SHALL assert cmd_ready in the first cycle after reset_n rises.

Structure
REQ-034 SHALL place the FSM state enum, the coordinate widths (10/9), the color width (8) and the address packing function in shared package vga_draw_pkg.
REQ-035 SHALL be a single module, optionally with one sub-module bresenham_step holding the combinational err/x/y next-value logic.

Verification
REQ-036 SHALL cover: (0,0)->(3,0), color 0xE0, waitrequest=0 -> writes at BASE+0,1,2,3 on consecutive cycles, done pulse, pixel_count=4.
REQ-037 SHALL cover: (0,0)->(2,2) -> writes at BASE+0x000, 0x401, 0x802, pixel_count=3.
REQ-038 SHALL cover: (5,7)->(5,7) -> a single write at BASE+0x1C05, then done.
REQ-039 SHALL cover: (0,0)->(1,0) with m_waitrequest high for 3 cycles on the first write -> address/data held 4 cycles, then the second write, pixel_count=2.
REQ-040 SHALL cover: (638,0)->(641,0) -> writes only at x=638 and 639, pixel_count=2, done still pulses.
REQ-041 SHALL cover: reset_n low mid-line (x0=0, x1=100) -> m_write=0 immediately, IDLE, no further writes, cmd_ready high after release.
